dm_timer: RTL and testbench

Memory-mapped countdown timer on the CPU data port, downstream of the pipelined core. It consumes the M-stage outputs `m_data_addr`, `m_data_wdata` and `m_data_byteen`, and drives a read word that the system bridge muxes onto `m_data_rdata`. It implements a 4-state counter FSM, one-shot and auto-reload modes, and a maskable interrupt line for the core's future exception logic.

---
 rtl/dm_timer_if.sv | 12 +
 rtl/dm_timer.sv | 101 ++++++++++
 tb/tb_dm_timer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_timer_if.sv
// CPU data-port view of dm_timer: M-stage address, write data and byte enables in;
// read word and interrupt request out.
interface dm_timer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, wdata, byteen, input rdata, irq);
  modport slave  (input addr, wdata, byteen, output rdata, irq);
endinterface

// File: rtl/dm_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT window at BASE_ADDR, one-shot or
// auto-reload counting through a four-state FSM, and a maskable interrupt.
module dm_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input logic        clk,
  input logic        reset,
  dm_timer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic hit;
  logic wr_ok;
  logic wr_ctrl;
  logic wr_preset;
  logic unused_addr_bits;

  // Word offset 3 (+C) lies inside the 16-byte decode but is not a register.
  assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'b11);
  assign wr_ok     = hit && (bus.byteen == 4'b1111);
  assign wr_ctrl   = wr_ok && (bus.addr[3:2] == 2'b00);
  assign wr_preset = wr_ok && (bus.addr[3:2] == 2'b01);

  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (bus.addr[3:2])
        2'b00:   bus.rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        2'b01:   bus.rdata = preset;
        2'b10:   bus.rdata = count;
        default: bus.rdata = '0;
      endcase
    end
  end

  assign bus.irq = ctrl_im & irq_flag;

  // NOTE: every register here, wide ones included, is plain flops and must reach a
  // known zero on reset; there is no memory array that could be left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ctrl_en) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en) begin
            state <= S_IDLE;
          end else if (count == 32'd0) begin
            state    <= S_INT;
            irq_flag <= 1'b1;
          end else begin
            count <= count - 32'd1;
          end
        end
        S_INT: begin
          if (ctrl_mode == 2'd1) begin
            irq_flag <= 1'b0;
            state    <= S_LOAD;
          end else begin
            ctrl_en <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // NOTE: non-blocking assignments to the same register resolve last-wins, so the
      // CPU write below overrides the FSM's EN clear and irq_flag set on the same edge.
      if (wr_ctrl) begin
        ctrl_en   <= bus.wdata[0];
        ctrl_mode <= bus.wdata[2:1];
        ctrl_im   <= bus.wdata[3];
      end
      if (wr_preset) preset <= bus.wdata;
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_timer.sv
// Self-checking bench for dm_timer: randomized presets and timings checked against
// a timeline model derived from the documented edge-by-edge behaviour.
module tb_dm_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;
  localparam logic [31:0] A_MISS = BASE + 32'd12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  dm_timer_if bus ();

  dm_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: timeline after the enabling write edge E0 ----------------
  // k counts edges after E0; values are those visible between edge k and edge k+1.
  function automatic logic [31:0] os_count(input int n, input int k);
    if (k <= n + 2) return 32'(n - (k - 2));
    return 32'd0;
  endfunction

  function automatic logic os_flag(input int n, input int k);
    return k >= n + 3;
  endfunction

  function automatic logic [31:0] ar_count(input int n, input int k);
    int p;
    p = (k - 2) % (n + 3);
    if (p <= n) return 32'(n - p);
    return 32'd0;
  endfunction

  function automatic logic ar_flag(input int n, input int k);
    return (k >= n + 3) && (((k - n - 3) % (n + 3)) == 0);
  endfunction

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    @(negedge clk);
    bus.byteen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.byteen = 4'h0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] v;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.addr   = BASE + 32'(4 * $urandom_range(0, 3));
      bus.wdata  = $urandom;
      bus.byteen = 4'hF;
    end
    @(negedge clk);
    bus.byteen = 4'h0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL reset_rdata off=%0d got=%h exp=0", 4 * i, d);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", bus.irq);
    end

    v = $urandom | 32'h1;
    wr(A_MISS, v, 4'hF);
    wr(A_PRE, v, 4'b0011);
    wr(A_PRE ^ 32'h0001_0000, v, 4'hF);
    wr(A_CTRL ^ 32'h0000_0010, 32'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL ignored_write off=%0d got=%h exp=0", 4 * i, d);
      end
    end

    wr(A_PRE, v, 4'hF);
    rd(A_PRE | 32'h3, d);
    checks++;
    if (d !== v) begin
      failures++;
      $display("FAIL preset_unaligned_read got=%h exp=%h", d, v);
    end
    rd(A_PRE ^ 32'h0001_0000, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL alias_read got=%h exp=0", d);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int n;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 5 : (r == 1) ? 0 : int'($urandom_range(1, 12));
      do_reset();
      wr(A_PRE, 32'(n), 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      for (int k = 1; k <= n + 6; k++) begin
        @(negedge clk);
        rd(A_CNT, d);
        if (k >= 2) begin
          checks++;
          if (d !== os_count(n, k)) begin
            failures++;
            $display("FAIL oneshot_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, os_count(n, k));
          end
        end
        checks++;
        if (bus.irq !== os_flag(n, k)) begin
          failures++;
          $display("FAIL oneshot_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, os_flag(n, k));
        end
        if (k >= n + 4) begin
          rd(A_CTRL, d);
          checks++;
          if (d !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_ctrl n=%0d k=%0d got=%h exp=8", n, k, d);
          end
        end
      end
      wr(A_CTRL, 32'h0, 4'hF);
      #1;
      checks++;
      if (bus.irq !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_irq_clear n=%0d got=%b exp=0", n, bus.irq);
      end
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    int n;
    n = int'($urandom_range(1, 8));
    do_reset();
    wr(A_PRE, 32'(n), 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= n + 6; k++) begin
      @(negedge clk);
      rd(A_CNT, d);
      if (k >= 2) begin
        checks++;
        if (d !== os_count(n, k)) begin
          failures++;
          $display("FAIL mask_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, os_count(n, k));
        end
      end
      checks++;
      if (bus.irq !== 1'b0) begin
        failures++;
        $display("FAIL mask_irq n=%0d k=%0d got=%b exp=0", n, k, bus.irq);
      end
    end
    // The CTRL write that sets IM is itself an accepted write, so the pending flag clears.
    wr(A_CTRL, 32'h8, 4'hF);
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL mask_set_im_irq got=%b exp=0", bus.irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int n;
    int pulses;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 2 : int'($urandom_range(1, 6));
      pulses = 0;
      do_reset();
      wr(A_PRE, 32'(n), 4'hF);
      wr(A_CTRL, 32'hB, 4'hF);
      for (int k = 1; k <= 5 * (n + 3) + 2; k++) begin
        @(negedge clk);
        rd(A_CNT, d);
        if (k >= 2) begin
          checks++;
          if (d !== ar_count(n, k)) begin
            failures++;
            $display("FAIL reload_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, ar_count(n, k));
          end
        end
        checks++;
        if (bus.irq !== ar_flag(n, k)) begin
          failures++;
          $display("FAIL reload_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, ar_flag(n, k));
        end
        if (bus.irq === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 5) begin
        failures++;
        $display("FAIL reload_pulses n=%0d got=%0d exp=5", n, pulses);
      end
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int stop;
    bit found;
    for (int r = 0; r < 2; r++) begin
      stop = (r == 0) ? 40 : int'($urandom_range(5, 90));
      found = 1'b0;
      do_reset();
      wr(A_PRE, 32'd100, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      for (int i = 0; i < 300; i++) begin
        rd(A_CNT, d);
        if (d == 32'(stop + 1)) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL disable_reach stop=%0d got=timeout exp=count_%0d", stop, stop + 1);
      end else begin
        wr(A_CTRL, 32'h8, 4'hF);
        for (int j = 0; j < 6; j++) begin
          rd(A_CNT, d);
          checks++;
          if (d !== 32'(stop)) begin
            failures++;
            $display("FAIL disable_hold stop=%0d j=%0d got=%0d exp=%0d", stop, j, d, stop);
          end
          @(negedge clk);
        end
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          rd(A_CNT, d);
          checks++;
          if (d !== ((k < 2) ? 32'(stop) : os_count(100, k))) begin
            failures++;
            $display("FAIL reenable_count stop=%0d k=%0d got=%0d", stop, k, d);
          end
        end
      end
    end
  endtask

  task automatic test_preset_midcount();
    logic [31:0] d;
    int n;
    int j;
    n = int'($urandom_range(20, 40));
    j = int'($urandom_range(2, 10));
    do_reset();
    wr(A_PRE, 32'(n), 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    repeat (j) @(negedge clk);
    wr(A_PRE, 32'd3, 4'hF);
    for (int k = j + 1; k <= n + 4; k++) begin
      if (k > j + 1) @(negedge clk);
      rd(A_CNT, d);
      checks++;
      if (d !== os_count(n, k)) begin
        failures++;
        $display("FAIL preset_mid_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, os_count(n, k));
      end
      checks++;
      if (bus.irq !== os_flag(n, k)) begin
        failures++;
        $display("FAIL preset_mid_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, os_flag(n, k));
      end
    end
    rd(A_PRE, d);
    checks++;
    if (d !== 32'd3) begin
      failures++;
      $display("FAIL preset_mid_value got=%0d exp=3", d);
    end
    wr(A_CTRL, 32'h9, 4'hF);
    repeat (2) @(negedge clk);
    rd(A_CNT, d);
    checks++;
    if (d !== 32'd3) begin
      failures++;
      $display("FAIL preset_next_load got=%0d exp=3", d);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    bit found;
    found = 1'b0;
    do_reset();
    wr(A_PRE, 32'($urandom_range(10, 30)), 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int i = 0; i < 100; i++) begin
      rd(A_CNT, d);
      if (d == 32'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_reach got=timeout exp=count_7");
    end
    reset = 1'b0;
    #1;
    rd(A_CNT, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_count got=%0d exp=0", d);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_irq got=%b exp=0", bus.irq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rd(A_CNT, d);
      checks++;
      if (d !== 32'd0 || bus.irq !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_restart k=%0d got_count=%0d got_irq=%b exp=0/0", k, d, bus.irq);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    int n;
    n = int'($urandom_range(1, 6));
    do_reset();
    wr(A_PRE, 32'(n), 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    repeat (n + 3) @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL simul_int_reached got=%b exp=1", bus.irq);
    end
    wr(A_CTRL, 32'h9, 4'hF);
    rd(A_CTRL, d);
    checks++;
    if (d !== 32'h9) begin
      failures++;
      $display("FAIL simul_ctrl got=%h exp=9", d);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL simul_irq got=%b exp=0", bus.irq);
    end
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      rd(A_CNT, d);
      if (k >= 2) begin
        checks++;
        if (d !== os_count(n, k)) begin
          failures++;
          $display("FAIL simul_rerun_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, os_count(n, k));
        end
      end
      checks++;
      if (bus.irq !== os_flag(n, k)) begin
        failures++;
        $display("FAIL simul_rerun_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, os_flag(n, k));
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.byteen = 4'h0;
    test_reset();
    test_oneshot();
    test_mask();
    test_autoreload();
    test_disable();
    test_preset_midcount();
    test_reset_midcount();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
